// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, oversampling
// ratio and the baud divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int OS = 16;

    function automatic int uart_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OS);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Parallel side of the UART receiver: line input, enable, received word,
// completion strobe and status flags.
interface uart_rx_os16_if #(
    parameter int DATA_BITS = 8
);
    logic                 uart_en;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_busy;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_error;

    modport master (
        output uart_en, rx,
        input  rx_data, rx_done, rx_busy, rx_frame_err, rx_parity_err, rx_error
    );

    modport slave (
        input  uart_en, rx,
        output rx_data, rx_done, rx_busy, rx_frame_err, rx_parity_err, rx_error
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks while enabled,
// counter held at zero while restart is asserted.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic arst,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(DIV - 1));
    assign tick = en && !restart && wrap;

    // NOTE: sequential state is assigned with <= so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt <= '0;
        end else if (restart || !en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver with 16x oversampling and a mid-bit sample; defining
// UART_RX_MAJORITY_EN replaces the single sample with a 2-of-3 vote at ticks 6/7/8.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic          clk,
    input  logic          arst,
    uart_rx_os16_if.slave bus
);
    localparam int DIV = uart_div(CLK_FREQ, BAUD);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SAMPLE_TICK = 4'd8;
`else
    localparam logic [3:0] SAMPLE_TICK = 4'd7;
`endif

    uart_state_t          state, state_next;
    logic                 rx_meta, rx_s;
    logic                 tick, mid, bit_end, last_bit, sample_bit;
    logic                 line_idle, parity_err_q;
    logic [3:0]           sample_cnt, bit_idx;
    logic [DATA_BITS-1:0] shift;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .arst    (arst),
        .en      (1'b1),
        .restart (state == IDLE),
        .tick    (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic vote6, vote7;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vote6 <= 1'b1;
            vote7 <= 1'b1;
        end else if (tick) begin
            if (sample_cnt == 4'd6) vote6 <= rx_s;
            if (sample_cnt == 4'd7) vote7 <= rx_s;
        end
    end

    assign sample_bit = (vote6 & vote7) | (vote6 & rx_s) | (vote7 & rx_s);
`else
    assign sample_bit = rx_s;
`endif

    assign mid      = tick && (sample_cnt == SAMPLE_TICK);
    assign bit_end  = tick && (sample_cnt == 4'd15);
    assign last_bit = (bit_idx == 4'(DATA_BITS - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.uart_en && line_idle && !rx_s) state_next = START;
            START: begin
                if (mid && sample_bit) state_next = IDLE;
                else if (bit_end)      state_next = DATA;
            end
            DATA:    if (bit_end && last_bit) state_next = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (mid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sample_cnt        <= '0;
            bit_idx           <= '0;
            shift             <= '0;
            line_idle         <= 1'b1;
            parity_err_q      <= 1'b0;
            bus.rx_data       <= '0;
            bus.rx_done       <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_error      <= 1'b0;
        end else begin
            bus.rx_done <= 1'b0;

            if (state == IDLE) sample_cnt <= '0;
            else if (tick)     sample_cnt <= sample_cnt + 4'd1;

            if (state != DATA)  bit_idx <= '0;
            else if (bit_end)   bit_idx <= last_bit ? 4'd0 : bit_idx + 4'd1;

            // LSB arrives first, so shifting in at the top leaves bit 0 at the bottom.
            if (state == DATA && mid) shift <= {sample_bit, shift[DATA_BITS-1:1]};

            if (state == START)              parity_err_q <= 1'b0;
            else if (state == PARITY && mid) parity_err_q <= ((^shift) ^ sample_bit) != (PARITY_ODD != 0);

            if (state == IDLE && rx_s)                    line_idle <= 1'b1;
            else if (state == STOP && mid && !sample_bit) line_idle <= 1'b0;

            if (state == STOP && mid) begin
                bus.rx_data       <= shift;
                bus.rx_done       <= 1'b1;
                bus.rx_frame_err  <= ~sample_bit;
                bus.rx_parity_err <= parity_err_q;
                bus.rx_error      <= ~sample_bit | parity_err_q;
            end
        end
    end

    assign bus.rx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: an 8N1 and an 8E1 instance at 16 clks per bit,
// frames built from a behavioural model of the serial format.
module tb_uart_rx_os16;
    localparam int CF  = 1_600_000;
    localparam int BD  = 100_000;
    localparam int BIT = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       err;
    } rec_t;

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic line_a = 1'b1;
    logic line_p = 1'b1;
    logic en = 1'b1;

    always #5 clk = ~clk;

    uart_rx_os16_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_os16_if #(.DATA_BITS(8)) bus_p ();

    assign bus_a.uart_en = en;
    assign bus_a.rx      = line_a;
    assign bus_p.uart_en = en;
    assign bus_p.rx      = line_p;

    uart_rx_os16 #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .arst(arst), .bus(bus_a.slave));
    uart_rx_os16 #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .arst(arst), .bus(bus_p.slave));

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t got_a[$];
    rec_t got_p[$];
    rec_t exp_q[$];
    int   busy_cyc = 0;
    int   busy_runs = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (bus_a.rx_done === 1'b1)
            got_a.push_back({bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_error});
        if (bus_p.rx_done === 1'b1)
            got_p.push_back({bus_p.rx_data, bus_p.rx_frame_err, bus_p.rx_parity_err, bus_p.rx_error});
        if (bus_a.rx_busy === 1'b1) busy_cyc++;
        if (bus_a.rx_busy === 1'b1 && prev_busy !== 1'b1) busy_runs++;
        prev_busy = bus_a.rx_busy;
    end

    // Expected receiver report for one frame, from the serial format rules.
    function automatic rec_t model(input bit par, input logic [7:0] d, input logic pbit, input logic stop);
        rec_t r;
        r.data = d;
        r.fe   = !stop;
        r.pe   = par && (((int'($countones(d)) + int'(pbit)) % 2) == 1);
        r.err  = r.fe | r.pe;
        return r;
    endfunction

    task automatic drive(input bit par, input logic v);
        if (par) line_p = v;
        else     line_a = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input bit par, input logic [7:0] d, input logic pbit,
                              input logic stop, input int en_off_bit);
        drive(par, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == en_off_bit) en = 1'b0;
            drive(par, d[i]);
        end
        if (par) drive(par, pbit);
        drive(par, stop);
    endtask

    task automatic test_reset;
        logic [12:0] obs;
        repeat (3) @(negedge clk);
        obs = {bus_a.rx_data, bus_a.rx_done, bus_a.rx_busy, bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_error};
        n_cmp++;
        if (obs !== 13'd0) begin n_bad++; $display("FAIL reset_a: got %h expected 0", obs); end
        obs = {bus_p.rx_data, bus_p.rx_done, bus_p.rx_busy, bus_p.rx_frame_err, bus_p.rx_parity_err, bus_p.rx_error};
        n_cmp++;
        if (obs !== 13'd0) begin n_bad++; $display("FAIL reset_p: got %h expected 0", obs); end
        arst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1;
        rec_t g, e;
        got_a.delete();
        busy_cyc = 0; busy_runs = 0;
        send_frame(0, 8'hD3, 1'b0, 1'b1, -1);
        repeat (8) @(negedge clk);
        e = model(0, 8'hD3, 1'b0, 1'b1);
        n_cmp++;
        if (got_a.size() !== 1) begin n_bad++; $display("FAIL 8n1_count: got %0d expected 1", got_a.size()); end
        g = (got_a.size() > 0) ? got_a[0] : 'x;
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL 8n1_frame: got %h expected %h", g, e); end
        n_cmp++;
        if (busy_cyc !== 152 + MAJ) begin n_bad++; $display("FAIL 8n1_busy_len: got %0d expected %0d", busy_cyc, 152 + MAJ); end
        n_cmp++;
        if (busy_runs !== 1) begin n_bad++; $display("FAIL 8n1_busy_runs: got %0d expected 1", busy_runs); end
    endtask

    task automatic test_parity;
        rec_t g;
        got_p.delete();
        exp_q.delete();
        send_frame(1, 8'hD3, 1'b1, 1'b1, -1);
        exp_q.push_back(model(1, 8'hD3, 1'b1, 1'b1));
        send_frame(1, 8'hD3, 1'b0, 1'b1, -1);
        exp_q.push_back(model(1, 8'hD3, 1'b0, 1'b1));
        repeat (8) @(negedge clk);
        n_cmp++;
        if (got_p.size() !== 2) begin n_bad++; $display("FAIL parity_count: got %0d expected 2", got_p.size()); end
        for (int i = 0; i < 2; i++) begin
            g = (i < got_p.size()) ? got_p[i] : 'x;
            n_cmp++;
            if (g !== exp_q[i]) begin n_bad++; $display("FAIL parity_frame%0d: got %h expected %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_frame_err;
        rec_t g;
        got_a.delete();
        exp_q.delete();
        send_frame(0, 8'h55, 1'b0, 1'b0, -1);
        exp_q.push_back(model(0, 8'h55, 1'b0, 1'b0));
        busy_cyc = 0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (busy_cyc !== 0 || got_a.size() !== 1) begin
            n_bad++; $display("FAIL break_hold: got busy %0d frames %0d expected busy 0 frames 1", busy_cyc, got_a.size());
        end
        line_a = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(0, 8'hA5, 1'b0, 1'b1, -1);
        exp_q.push_back(model(0, 8'hA5, 1'b0, 1'b1));
        repeat (8) @(negedge clk);
        n_cmp++;
        if (got_a.size() !== 2) begin n_bad++; $display("FAIL ferr_count: got %0d expected 2", got_a.size()); end
        for (int i = 0; i < 2; i++) begin
            g = (i < got_a.size()) ? got_a[i] : 'x;
            n_cmp++;
            if (g !== exp_q[i]) begin n_bad++; $display("FAIL ferr_frame%0d: got %h expected %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_glitch;
        got_a.delete();
        busy_cyc = 0;
        line_a = 1'b0;
        repeat (4) @(negedge clk);
        line_a = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (got_a.size() !== 0) begin n_bad++; $display("FAIL glitch_done: got %0d expected 0", got_a.size()); end
        n_cmp++;
        if (busy_cyc !== 8 + MAJ) begin n_bad++; $display("FAIL glitch_busy_len: got %0d expected %0d", busy_cyc, 8 + MAJ); end
        n_cmp++;
        if (bus_a.rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy: got %b expected 0", bus_a.rx_busy); end
    endtask

    task automatic test_back_to_back;
        rec_t g;
        logic [7:0] seq [3];
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
        for (int round = 0; round < 2; round++) begin
            got_a.delete();
            exp_q.delete();
            for (int k = 0; k < 3; k++) begin
                send_frame(0, seq[k], 1'b0, 1'b1, (round == 1 && k == 1) ? 4 : -1);
                if (round == 0 || k < 2) exp_q.push_back(model(0, seq[k], 1'b0, 1'b1));
            end
            repeat (20) @(negedge clk);
            en = 1'b1;
            n_cmp++;
            if (got_a.size() !== exp_q.size()) begin
                n_bad++; $display("FAIL b2b_count%0d: got %0d expected %0d", round, got_a.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                g = (i < got_a.size()) ? got_a[i] : 'x;
                n_cmp++;
                if (g !== exp_q[i]) begin n_bad++; $display("FAIL b2b_frame%0d_%0d: got %h expected %h", round, i, g, exp_q[i]); end
            end
        end
    endtask

    task automatic test_arst_midframe;
        rec_t g, e;
        logic [12:0] obs;
        logic busy_before;
        got_a.delete();
        fork
            send_frame(0, 8'h5A, 1'b0, 1'b1, -1);
            begin
                repeat (BIT * 4 + 8) @(negedge clk);
                busy_before = bus_a.rx_busy;
                arst = 1'b1;
                #1;
                obs = {bus_a.rx_data, bus_a.rx_done, bus_a.rx_busy, bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_error};
                n_cmp++;
                if (busy_before !== 1'b1) begin n_bad++; $display("FAIL arst_busy_before: got %b expected 1", busy_before); end
                n_cmp++;
                if (obs !== 13'd0) begin n_bad++; $display("FAIL arst_outputs: got %h expected 0", obs); end
            end
        join
        repeat (4) @(negedge clk);
        arst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (got_a.size() !== 0) begin n_bad++; $display("FAIL arst_no_done: got %0d expected 0", got_a.size()); end
        send_frame(0, 8'h81, 1'b0, 1'b1, -1);
        repeat (8) @(negedge clk);
        e = model(0, 8'h81, 1'b0, 1'b1);
        g = (got_a.size() > 0) ? got_a[0] : 'x;
        n_cmp++;
        if (got_a.size() !== 1 || g !== e) begin
            n_bad++; $display("FAIL arst_recover: got %0d frames first %h expected 1 frame %h", got_a.size(), g, e);
        end
    endtask

    task automatic test_random;
        rec_t g;
        logic [7:0] d;
        logic pbit, stop;
        for (int par = 0; par < 2; par++) begin
            got_a.delete();
            got_p.delete();
            exp_q.delete();
            for (int n = 0; n < 12; n++) begin
                d    = 8'($urandom);
                pbit = 1'($urandom_range(0, 1));
                stop = ($urandom_range(0, 3) != 0);
                exp_q.push_back(model(par != 0, d, pbit, stop));
                send_frame(par != 0, d, pbit, stop, -1);
                if (!stop) drive(par != 0, 1'b1);
            end
            repeat (8) @(negedge clk);
            n_cmp++;
            if ((par ? got_p.size() : got_a.size()) !== exp_q.size()) begin
                n_bad++; $display("FAIL rand_count%0d: got %0d expected %0d", par, par ? got_p.size() : got_a.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                if (par != 0) g = (i < got_p.size()) ? got_p[i] : 'x;
                else          g = (i < got_a.size()) ? got_a[i] : 'x;
                n_cmp++;
                if (g !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_frame%0d: got %h expected %h", par, i, g, exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_arst_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
Standalone UART receiver that recovers serial frames sent by the team's UART transmitter.
- Frame format: start bit, DATA_BITS data bits LSB first, optional parity bit, one stop bit.
- Line is sampled at 16x the baud rate with a mid-bit sampling point.
- Sits at the FPGA pin boundary and feeds a parallel byte, a done strobe and error flags to the user logic.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line baud rate
DATA_BITS, 8, data bits per frame (5..9)
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only if PARITY_EN=1)

Ports:
clk  input  1  system clock, rising edge
arst  input  1  asynchronous, active-high reset
uart_en  input  1  receive enable; gates acceptance of a new start bit only
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last received word
rx_done  output  1  one-cycle strobe: frame complete, outputs valid
rx_busy  output  1  frame in progress
rx_frame_err  output  1  stop bit sampled low, valid with rx_done
rx_parity_err  output  1  parity mismatch, valid with rx_done
rx_error  output  1  rx_frame_err | rx_parity_err

Behaviour:
- Interface (already decided): one clock `clk`; reset `arst` is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - Synchronizer flops = 1.
  - State IDLE, counters 0, line_idle = 1.
- Input path: rx passes through a 2-FF synchronizer; rx_s is the synchronized value.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer, minimum 1.
  - Emits a one-clk tick every DIV clocks.
  - Restarts at 0 when leaving IDLE.
- Sample counter: counts ticks 0..15 per bit. The mid-bit sample is taken on tick 7.
- State IDLE:
  - rx_busy = 0.
  - line_idle is set whenever rx_s = 1.
  - If uart_en = 1, line_idle = 1 and rx_s = 0, go to START.
- State START:
  - At tick 7, if rx_s = 1 (glitch), return to IDLE with no strobe.
  - Otherwise, at tick 15 go to DATA with bit index 0.
- State DATA:
  - At tick 7, shift rx_s into the MSB of the shift register (LSB-first frame).
  - At tick 15, increment the bit index.
  - After DATA_BITS bits, go to PARITY if PARITY_EN = 1, else go to STOP.
- State PARITY:
  - At tick 7, compute the error: parity_err = (^shift ^ rx_s) != PARITY_ODD.
  - At tick 15, go to STOP.
- State STOP:
  - At tick 7, in the same clk:
    - Load rx_data from the shift register.
    - Set rx_frame_err = ~rx_s and rx_parity_err.
    - Pulse rx_done for exactly one clk.
  - Go directly to IDLE on that clk. No wait for the end of the stop bit, so back-to-back frames are accepted.
  - If rx_s = 0 (framing error or break), clear line_idle. A new start is then accepted only after rx_s has returned high.
- rx_busy = 1 in START, DATA, PARITY and STOP.
- Output hold: rx_data and the error flags hold until the next rx_done.
- Latency: rx_done rises 2 clks (synchronizer) + ~(DIV*8) clks after the stop-bit edge on the pin.
- uart_en deasserted mid-frame: the frame completes normally; it only blocks the next start.
- arst mid-frame: immediate return to reset values; no rx_done.
- Simultaneous: rx_done and an IDLE start detection cannot share a cycle; STOP→IDLE costs 1 clk, well inside the half stop bit.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: every mid-bit sample (start, data, parity, stop) is the 2-of-3 majority of rx_s at ticks 6, 7 and 8, decided at tick 8. The START glitch check uses the same vote.
- Undefined: single sample at tick 7, as above.

Decomposition:
- Package uart_pkg holds:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constant OS = 16.
  - Function uart_div(CLK_FREQ, BAUD).
- Sub-module uart_baud_tick (enable, restart, tick out) is shared with the transmitter.

Test Plan:
All cases use CLK_FREQ = 1_600_000 and BAUD = 100_000, giving DIV = 1 and 16 clks per bit.
1. 8N1 send 0xD3 → rx_done pulses once; rx_data = 0xD3; rx_error = 0; rx_busy high from start detect to the strobe.
2. Even parity (PARITY_EN = 1), send 0xD3 with parity bit 1, then 0xD3 with parity bit 0 → first frame rx_parity_err = 0; second frame rx_parity_err = 1, rx_error = 1, rx_data = 0xD3.
3. Stop bit driven 0 on a 0x55 frame → rx_frame_err = 1, rx_data = 0x55. Then hold rx low for 40 clks → no new frame. Release high, send 0xA5 → rx_data = 0xA5, no error.
4. 4-clk low glitch on an idle line → no rx_busy after the START check, no rx_done.
5. Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap → three rx_done strobes with the correct data. Deassert uart_en mid second frame → that frame completes, the third is ignored.
6. Assert arst at data bit 3 → all outputs 0 within the same cycle. Release and send 0x81 → rx_data = 0x81.
